// File: rtl/tdm_pkg.sv
// Shared constants and types for the eight-channel TDM scanner.
// Imported by the channel picker and the scanner top.
package tdm_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DWELL = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin channel picker: next enabled channel after cur (with wrap)
// and the lowest enabled channel of the mask.
module rr_next_ch
    import tdm_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [NCH-1:0]   mask,
    output logic [SEL_W-1:0] next_ch,
    output logic             wrap,
    output logic [SEL_W-1:0] lowest
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        next_ch = cur;
        found   = 1'b0;
        idx     = cur;
        // offset 8 lands back on cur, covering a single-channel mask
        for (int i = 1; i <= NCH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
        wrap = found && (next_ch <= cur);
    end

    always_comb begin
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) lowest = SEL_W'(i);
        end
    end

endmodule

// File: rtl/tdm_mux_81_scan.sv
// Eight-channel round-robin TDM multiplexer with per-channel dwell,
// hold freeze and channel masking.
module tdm_mux_81_scan
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hold,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [WIDTH-1:0] data_in_0,
    input  logic [WIDTH-1:0] data_in_1,
    input  logic [WIDTH-1:0] data_in_2,
    input  logic [WIDTH-1:0] data_in_3,
    input  logic [WIDTH-1:0] data_in_4,
    input  logic [WIDTH-1:0] data_in_5,
    input  logic [WIDTH-1:0] data_in_6,
    input  logic [WIDTH-1:0] data_in_7,
    output logic [WIDTH-1:0] data_out,
    output logic [SEL_W-1:0] sel_out,
    output logic             valid,
    output logic             frame_start
);

    localparam int          CW   = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [SEL_W-1:0] sel_n;
    logic [WIDTH-1:0] dout_n;
    logic             valid_n, fs_n;

    logic [WIDTH-1:0] din [NCH];
    logic [SEL_W-1:0] next_ch, lowest;
    logic             wrap;

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign din[2] = data_in_2;
    assign din[3] = data_in_3;
    assign din[4] = data_in_4;
    assign din[5] = data_in_5;
    assign din[6] = data_in_6;
    assign din[7] = data_in_7;

    rr_next_ch u_pick (
        .cur     (sel_out),
        .mask    (ch_mask),
        .next_ch (next_ch),
        .wrap    (wrap),
        .lowest  (lowest)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel_out;
        dout_n  = din[sel_out];
        valid_n = 1'b1;
        fs_n    = 1'b0;
        if (!en || ch_mask == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
            dout_n  = '0;
            valid_n = 1'b0;
        end else if (state == IDLE) begin
            state_n = SCAN;
            cnt_n   = '0;
            sel_n   = lowest;
            dout_n  = din[lowest];
            fs_n    = 1'b1;
        end else if (!ch_mask[sel_out]) begin
            // current channel dropped out: leave it at once, even in hold
            state_n = hold ? HOLD : SCAN;
            cnt_n   = '0;
            sel_n   = next_ch;
            dout_n  = din[next_ch];
            fs_n    = wrap;
        end else if (hold) begin
            state_n = HOLD;
        end else begin
            state_n = SCAN;
            if (cnt == LAST) begin
                cnt_n  = '0;
                sel_n  = next_ch;
                dout_n = din[next_ch];
                fs_n   = wrap;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_out     <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel_out     <= sel_n;
            data_out    <= dout_n;
            valid       <= valid_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_tdm_mux_81_scan.sv
// Directed scoreboard bench for tdm_mux_81_scan (WIDTH=4, DWELL=4).
// Expected outputs come from a cycle model queued at each driven edge.
module tb_tdm_mux_81_scan;

    localparam int W  = 4;
    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         rst_n, en, hold;
    logic [7:0]   ch_mask;
    logic [W-1:0] din [8];
    logic [W-1:0] data_out;
    logic [2:0]   sel_out;
    logic         valid, frame_start;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   s;
        logic         v;
        logic         f;
    } exp_t;

    exp_t q[$];
    int   nasrt = 0;
    int   nfail = 0;

    // model state: 0 idle, 1 scan, 2 hold
    int   m_st, m_cnt, m_sel;
    exp_t m_out;

    always #5 clk = ~clk;

    tdm_mux_81_scan #(.WIDTH(W), .DWELL(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hold        (hold),
        .ch_mask     (ch_mask),
        .data_in_0   (din[0]),
        .data_in_1   (din[1]),
        .data_in_2   (din[2]),
        .data_in_3   (din[3]),
        .data_in_4   (din[4]),
        .data_in_5   (din[5]),
        .data_in_6   (din[6]),
        .data_in_7   (din[7]),
        .data_out    (data_out),
        .sel_out     (sel_out),
        .valid       (valid),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int search_next(input int cur, input logic [7:0] m);
        int c = cur;
        for (int k = 0; k < 8; k++) begin
            c = (c + 1) % 8;
            if (m[c]) return c;
        end
        return cur;
    endfunction

    task automatic model_reset();
        m_st  = 0;
        m_cnt = 0;
        m_sel = 0;
        q.delete();
    endtask

    task automatic model_edge();
        int old;
        m_out.s = 3'(m_sel);
        m_out.f = 1'b0;
        m_out.v = 1'b1;
        if (!en || ch_mask == 8'h00) begin
            m_st  = 0;
            m_cnt = 0;
            m_out.v = 1'b0;
        end else if (m_st == 0) begin
            m_st  = 1;
            m_cnt = 0;
            m_sel = search_next(7, ch_mask);
            m_out.f = 1'b1;
        end else if (!ch_mask[m_sel]) begin
            old   = m_sel;
            m_sel = search_next(old, ch_mask);
            m_cnt = 0;
            m_st  = hold ? 2 : 1;
            m_out.f = (m_sel <= old);
        end else if (hold) begin
            m_st = 2;
        end else begin
            m_st = 1;
            m_cnt++;
            if (m_cnt == DW) begin
                old   = m_sel;
                m_cnt = 0;
                m_sel = search_next(old, ch_mask);
                m_out.f = (m_sel <= old);
            end
        end
        m_out.s = 3'(m_sel);
        m_out.d = m_out.v ? din[m_sel] : '0;
        q.push_back(m_out);
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            nasrt++;
            nfail++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".valid"}, int'(valid), int'(e.v));
            chk({tag, ".frame"}, int'(frame_start), int'(e.f));
            chk({tag, ".data"}, int'(data_out), int'(e.d));
            if (e.v) chk({tag, ".sel"}, int'(sel_out), int'(e.s));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, int'(valid), 0);
        chk({tag, ".frame"}, int'(frame_start), 0);
        chk({tag, ".data"}, int'(data_out), 0);
        chk({tag, ".sel"}, int'(sel_out), 0);
    endtask

    task automatic run_until(input int sel, input int cnt, input string tag);
        int budget = 64;
        while (!(m_sel == sel && m_cnt == cnt) && budget > 0) begin
            step(tag);
            budget--;
        end
        if (budget == 0) begin
            nasrt++;
            nfail++;
            $error("FAIL %s: observed budget expired expected ch %0d", tag, sel);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        hold    = 1'b0;
        ch_mask = 8'h00;
        for (int i = 0; i < 8; i++) din[i] = W'(i);
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // full scan, two complete frames plus margin
        en      = 1'b1;
        ch_mask = 8'hFF;
        for (int i = 0; i < 70; i++) step("full");

        // asynchronous reset at an arbitrary phase
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("restart");
        for (int i = 0; i < 9; i++) step("restart");

        // sparse masks, entered from idle
        en = 1'b0;
        step("idle1");
        ch_mask = 8'b1010_0100;
        en      = 1'b1;
        for (int i = 0; i < 30; i++) step("sparse");
        en = 1'b0;
        step("idle2");
        ch_mask = 8'h10;
        en      = 1'b1;
        for (int i = 0; i < 13; i++) step("single");

        // hold on channel 3 with its data moving
        en = 1'b0;
        step("idle3");
        ch_mask = 8'hFF;
        en      = 1'b1;
        run_until(3, 1, "tohold");
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din[3] = W'($urandom_range(0, 15));
            step("hold");
        end
        hold = 1'b0;
        for (int i = 0; i < 8; i++) step("unhold");

        // mask the live channel while held
        din[3] = 4'd3;
        run_until(3, 2, "tomask");
        hold    = 1'b1;
        ch_mask = 8'hF7;
        step("maskoff");
        chk("maskoff.sel4", int'(sel_out), 4);
        step("maskhold");
        hold = 1'b0;
        for (int i = 0; i < 12; i++) step("masked");
        ch_mask = 8'h00;
        step("maskzero");
        step("maskzero");

        // enable drop and enable with empty mask
        ch_mask = 8'hFF;
        for (int i = 0; i < 5; i++) step("rescan");
        en = 1'b0;
        step("endrop");
        en      = 1'b1;
        ch_mask = 8'h00;
        for (int i = 0; i < 3; i++) step("nomask");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end

endmodule
